// File: rtl/stream_demux_n.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_n
// Purpose  : Packet-aware 1-to-N valid/ready stream demultiplexer. The first
//            word of a packet picks the destination channel from sel. That
//            route is held until the word carrying inLast has been accepted.
//            Each channel has a single output register, so latency is one
//            cycle. Words that select a channel that does not exist are
//            accepted, discarded and counted in a saturating error counter.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            inPort   - input data word (WIDTH)
//            inValid  - input word offered
//            inLast   - offered word closes its packet
//            inReady  - input word accepted this cycle when inValid is high
//            sel      - destination channel, sampled on the first packet word
//            outPort  - channel k data in bits [k*WIDTH +: WIDTH]
//            outValid - per-channel valid
//            outLast  - per-channel last flag
//            outReady - per-channel downstream ready
//            errCount - words dropped because of an out-of-range select
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2,
  parameter int ERRW     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          inPort,
  input  logic                      inValid,
  input  logic                      inLast,
  output logic                      inReady,
  input  logic [SELW-1:0]           sel,
  output logic [CHANNELS*WIDTH-1:0] outPort,
  output logic [CHANNELS-1:0]       outValid,
  output logic [CHANNELS-1:0]       outLast,
  input  logic [CHANNELS-1:0]       outReady,
  output logic [ERRW-1:0]           errCount
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  localparam logic [31:0] NUM_CH = CHANNELS;

  state_t          state;
  logic [SELW-1:0] curSel;
  logic [1:0]      rst_sync;
  logic            run;
  logic [SELW-1:0] route;
  logic [31:0]     route_ext;
  logic            route_ok;
  logic            route_ready;
  logic            accept;

  // Two-stage release synchroniser: the block stays closed until the second
  // rising edge after rst_n deasserts, so inReady never rises asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  // The destination is locked once a packet has started.
  assign route     = (state == ST_PKT) ? curSel : sel;
  assign route_ext = {{(32-SELW){1'b0}}, route};
  assign route_ok  = (route_ext < NUM_CH);

  // Space on the routed channel: empty now, or being drained this cycle.
  always_comb begin
    route_ready = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (route_ext == 32'(k)) begin
        route_ready = !outValid[k] || outReady[k];
      end
    end
  end

  // Out-of-range words are always taken so that they can be discarded.
  assign inReady = run && (!route_ok || route_ready);
  assign accept  = inValid && inReady;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      logic             load;
      logic [WIDTH-1:0] data_q;
      logic             last_q;
      logic             valid_q;

      assign load = accept && route_ok && (route_ext == 32'(k));

      // Data and last are cleared whenever the slot empties, so an idle
      // channel always reads as zero rather than showing stale data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          last_q  <= 1'b0;
          valid_q <= 1'b0;
        end else if (load) begin
          data_q  <= inPort;
          last_q  <= inLast;
          valid_q <= 1'b1;
        end else if (outReady[k]) begin
          data_q  <= '0;
          last_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      end

      assign outPort[k*WIDTH +: WIDTH] = data_q;
      assign outLast[k]                = last_q;
      assign outValid[k]               = valid_q;
    end
  endgenerate

  // Saturating count of discarded words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount <= '0;
    end else if (accept && !route_ok && (errCount != {ERRW{1'b1}})) begin
      errCount <= errCount + ERRW'(1);
    end
  end

  // Packet framing: follows inLast even for discarded words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      curSel <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (!inLast) begin
            state  <= ST_PKT;
            curSel <= sel;
          end
        end
        ST_PKT: begin
          if (inLast) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/stream_demux_n.md
STREAM_DEMUX_N -- requirements
Module: stream_demux_n

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, legal range 1..64.
REQ-002 Parameter CHANNELS, default 4: number of output channels, legal range 2..16.
REQ-003 Parameter SELW, default 2: select width, >= ceil(log2(CHANNELS)).
REQ-004 Parameter ERRW, default 8: width of the dropped-word counter.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 inPort  input  WIDTH  input data word.
REQ-008 inValid  input  1  a word is offered on inPort.
REQ-009 inLast  input  1  the offered word is the last word of its packet.
REQ-010 inReady  output  1  the block accepts the word this cycle.
REQ-011 sel  input  SELW  destination channel; sampled only on the first word of a packet.
REQ-012 outPort  output  CHANNELS*WIDTH  channel k data is in bits [k*WIDTH +: WIDTH].
REQ-013 outValid  output  CHANNELS  per-channel valid.
REQ-014 outLast  output  CHANNELS  per-channel last flag, qualified by outValid.
REQ-015 outReady  input  CHANNELS  per-channel downstream ready.
REQ-016 errCount  output  ERRW  count of words dropped because of an out-of-range select.

Function
REQ-017 Transfer rule: a word is accepted when inValid && inReady; an output word is consumed when outValid[k] && outReady[k].
REQ-018 Each channel SHALL have one output register holding data, last and valid; latency from acceptance to outValid is exactly 1 cycle.
REQ-019 The packet state machine SHALL have two states. IDLE: the route is taken from sel. PKT: the route is held in an internal register curSel.
REQ-020 IDLE to PKT: taken on an accepted word with inLast=0; curSel is loaded with sel in the same cycle.
REQ-021 PKT to IDLE: taken on an accepted word with inLast=1. An accepted word with inLast=1 in IDLE is a one-word packet, and the state stays IDLE.
REQ-022 The active route is sel in IDLE and curSel in PKT; changes on sel during PKT SHALL have no effect.
REQ-023 inReady = !outValid[route] || outReady[route], for an in-range route. The same-cycle pass-through lets a channel sustain one word per cycle.
REQ-024 When route >= CHANNELS: inReady=1, the word is discarded, no outValid is asserted, and errCount increments once per discarded word, saturating at all-ones. The state machine SHALL still follow inLast.
REQ-025 When outValid[k]=0, channel k data and last SHALL read as zero; non-selected channels never show stale or mirrored input data.
REQ-026 A channel register that is consumed and reloaded in the same cycle SHALL take the new word and keep outValid[k]=1.
REQ-027 A channel that is stalled (outReady low) SHALL hold its data and last stable until consumed; other channels drain independently.
REQ-028 inReady depends combinationally only on state, sel/curSel, outValid and outReady, never on inValid.

Reset
REQ-029 While rst_n=0: outValid, outLast, outPort, errCount and curSel are all 0; the state is IDLE; inReady is 0.
REQ-030 Reset asserted mid-packet SHALL discard every held word and the packet context with no partial output. After release, the first accepted word is treated as the start of a packet.
REQ-031 Reset release is synchronised internally so that inReady rises no earlier than the first rising clk edge after rst_n goes high.

Verification
REQ-032 Basic routing (WIDTH=16, CHANNELS=4): send one-word packets 0x1111/sel=0 through 0x4444/sel=3 with all outReady=1. Each word appears 1 cycle later on its own channel only; all other channels read 0.
REQ-033 Packet lock: a 3-word packet with sel=2 on the first word, and sel toggled to 1 on words 2 and 3. All 3 words exit channel 2; outLast[2] is set on word 3 only; the state returns to IDLE.
REQ-034 Backpressure: outReady[1]=0 with two words sent to channel 1. The first is held stable, inReady drops for the second; when outReady[1] goes high, the words drain in order at 1 per cycle. Channel 0 traffic is unaffected throughout.
REQ-035 Out-of-range select: CHANNELS=3 with 300 words at sel=3 and ERRW=8. errCount reaches 255 and stays there; no outValid is asserted; inReady stays 1.
REQ-036 Reset during packet: assert rst_n low after word 2 of a 4-word packet to channel 0. All outputs are 0 during reset; after release, a new word with sel=3 routes to channel 3.
REQ-037 Throughput: 100 back-to-back words to one channel with outReady held at 1. One word is delivered per cycle and no inReady bubbles occur.
